aggr_buffer_n: RTL

Parametrised per-bank aggregation buffer for the edge-PE datapath. It accumulates LANES-wide feature-vector beats for one node across multiple streams. On a done-aggregation stream it drains the sum to the reservation station with valid/ready backpressure. On a write-back stream it requests the output-SRAM port and drains the sum there after grant. It sits between an edge PE and the bank's RS and output-SRAM requester, and adds length/node checking and input backpressure.

---
 rtl/aggr_buffer_n.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aggr_buffer_n.sv
// aggr_buffer_n: per-bank feature-vector aggregation buffer with RS / output-SRAM drain.
// Define AGGR_BUF_SAT_EN for saturating accumulation; default build wraps modulo 2^DATA_W.
module aggr_buffer_n #(
   parameter int LANES    = 2,
   parameter int FV_DEPTH = 16,
   parameter int DATA_W   = 16,
   parameter int NODE_W   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sos,
   input  logic                      in_eos,
   input  logic [NODE_W-1:0]         in_nodeid,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic                      in_done_aggr,
   input  logic                      in_wb_en,
   output logic                      rs_valid,
   output logic                      rs_sos,
   output logic                      rs_eos,
   input  logic                      rs_ready,
   output logic [NODE_W-1:0]         rs_nodeid,
   output logic [LANES*DATA_W-1:0]   rs_data,
   output logic                      ob_req,
   input  logic                      ob_grant,
   output logic                      ob_valid,
   output logic                      ob_sos,
   output logic                      ob_eos,
   output logic [NODE_W-1:0]         ob_nodeid,
   output logic [LANES*DATA_W-1:0]   ob_data,
   output logic                      err_len,
   output logic                      err_node
);

   localparam int BEATS = FV_DEPTH / LANES;
   localparam int PTR_W = $clog2(BEATS + 1);
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int VEC_W = LANES * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM_IN,
      S_END,
      S_OUT_RS,
      S_OUT_WAIT,
      S_OUT_OB
   } state_t;

   state_t state;
   state_t state_next;

   logic [VEC_W-1:0]  acc [BEATS];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_inc;
   logic [IDX_W-1:0]  ptr_idx;
   logic [PTR_W-1:0]  len;
   logic [NODE_W-1:0] node;
   logic              has_data;
   logic              done_q;
   logic              wb_q;

   logic              take;
   logic              ingest_sos;
   logic              ingest_beat;
   logic              take_eos;
   logic              beat_first;
   logic              beat_last;
   logic [VEC_W-1:0]  beat_data;

   logic              rs_load;
   logic              ob_load;
   logic              drain_done;
   logic              in_ready_n;
   logic              rs_valid_n;
   logic              rs_sos_n;
   logic              rs_eos_n;
   logic [NODE_W-1:0] rs_nodeid_n;
   logic [VEC_W-1:0]  rs_data_n;
   logic              ob_req_n;
   logic              ob_valid_n;
   logic              ob_sos_n;
   logic              ob_eos_n;
   logic [NODE_W-1:0] ob_nodeid_n;
   logic [VEC_W-1:0]  ob_data_n;

   // Lane-wise signed add of one beat into an accumulator row.
   function automatic logic [VEC_W-1:0] add_beat(
      input logic [VEC_W-1:0] a,
      input logic [VEC_W-1:0] b
   );
      logic [VEC_W-1:0] r;
`ifdef AGGR_BUF_SAT_EN
      logic [DATA_W:0] s;
`endif
      r = '0;
      for (int i = 0; i < LANES; i++) begin
`ifdef AGGR_BUF_SAT_EN
         s = {a[i*DATA_W+DATA_W-1], a[i*DATA_W +: DATA_W]}
           + {b[i*DATA_W+DATA_W-1], b[i*DATA_W +: DATA_W]};
         if (s[DATA_W] != s[DATA_W-1])
            r[i*DATA_W +: DATA_W] = s[DATA_W] ?
               {1'b1, {(DATA_W-1){1'b0}}} :
               {1'b0, {(DATA_W-1){1'b1}}};
         else
            r[i*DATA_W +: DATA_W] = s[DATA_W-1:0];
`else
         r[i*DATA_W +: DATA_W] = a[i*DATA_W +: DATA_W]
                               + b[i*DATA_W +: DATA_W];
`endif
      end
      return r;
   endfunction

   // Ingest qualifiers and the drain beat currently addressed by ptr.
   assign take        = in_valid && in_ready;
   assign ingest_sos  = take && in_sos &&
                        ((state == S_IDLE) || (state == S_STREAM_IN));
   assign ingest_beat = take && !in_sos && (state == S_STREAM_IN);
   assign take_eos    = take && in_eos &&
                        (((state == S_IDLE) && in_sos) ||
                         (state == S_STREAM_IN));
   assign ptr_inc     = ptr + PTR_W'(1);
   assign ptr_idx     = ptr[IDX_W-1:0];
   assign beat_first  = (ptr == '0);
   assign beat_last   = (ptr_inc == len);
   assign beat_data   = acc[ptr_idx];

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (take && in_sos)
               state_next = in_eos ? S_END : S_STREAM_IN;
         end
         S_STREAM_IN: begin
            if (take && in_eos)
               state_next = S_END;
         end
         S_END: begin
            if (done_q)
               state_next = S_OUT_RS;
            else if (wb_q)
               state_next = S_OUT_WAIT;
            else
               state_next = S_IDLE;
         end
         S_OUT_RS: begin
            if (rs_valid && rs_ready && rs_eos)
               state_next = S_IDLE;
         end
         S_OUT_WAIT: begin
            if (ob_req && ob_grant)
               state_next = S_OUT_OB;
         end
         S_OUT_OB: begin
            if (ob_valid && ob_eos)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Next values for the registered outputs and drain control.
   always_comb begin
      in_ready_n  = (state_next == S_IDLE) ||
                    (state_next == S_STREAM_IN);
      rs_load     = (state == S_OUT_RS) &&
                    (!rs_valid || (rs_ready && !rs_eos));
      ob_load     = (state == S_OUT_OB) && !(ob_valid && ob_eos);
      drain_done  = ((state == S_OUT_RS) && rs_valid &&
                     rs_ready && rs_eos) ||
                    ((state == S_OUT_OB) && ob_valid && ob_eos);
      rs_valid_n  = 1'b0;
      rs_sos_n    = 1'b0;
      rs_eos_n    = 1'b0;
      rs_nodeid_n = '0;
      rs_data_n   = '0;
      ob_valid_n  = 1'b0;
      ob_sos_n    = 1'b0;
      ob_eos_n    = 1'b0;
      ob_nodeid_n = '0;
      ob_data_n   = '0;
      ob_req_n    = (state == S_OUT_WAIT) && !(ob_req && ob_grant);
      if (rs_load) begin
         rs_valid_n  = 1'b1;
         rs_sos_n    = beat_first;
         rs_eos_n    = beat_last;
         rs_nodeid_n = node;
         rs_data_n   = beat_data;
      end else if ((state == S_OUT_RS) && rs_valid && !rs_ready) begin
         rs_valid_n  = rs_valid;
         rs_sos_n    = rs_sos;
         rs_eos_n    = rs_eos;
         rs_nodeid_n = rs_nodeid;
         rs_data_n   = rs_data;
      end
      if (ob_load) begin
         ob_valid_n  = 1'b1;
         ob_sos_n    = beat_first;
         ob_eos_n    = beat_last;
         ob_nodeid_n = node;
         ob_data_n   = beat_data;
      end
   end

   // Accumulators, bookkeeping, sticky errors and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int b = 0; b < BEATS; b++)
            acc[b] <= '0;
         ptr       <= '0;
         len       <= '0;
         node      <= '0;
         has_data  <= 1'b0;
         done_q    <= 1'b0;
         wb_q      <= 1'b0;
         err_len   <= 1'b0;
         err_node  <= 1'b0;
         in_ready  <= 1'b1;
         rs_valid  <= 1'b0;
         rs_sos    <= 1'b0;
         rs_eos    <= 1'b0;
         rs_nodeid <= '0;
         rs_data   <= '0;
         ob_req    <= 1'b0;
         ob_valid  <= 1'b0;
         ob_sos    <= 1'b0;
         ob_eos    <= 1'b0;
         ob_nodeid <= '0;
         ob_data   <= '0;
      end else begin
         in_ready  <= in_ready_n;
         rs_valid  <= rs_valid_n;
         rs_sos    <= rs_sos_n;
         rs_eos    <= rs_eos_n;
         rs_nodeid <= rs_nodeid_n;
         rs_data   <= rs_data_n;
         ob_req    <= ob_req_n;
         ob_valid  <= ob_valid_n;
         ob_sos    <= ob_sos_n;
         ob_eos    <= ob_eos_n;
         ob_nodeid <= ob_nodeid_n;
         ob_data   <= ob_data_n;

         if (ingest_sos) begin
            acc[0] <= add_beat(acc[0], in_data);
            ptr    <= PTR_W'(1);
            node   <= in_nodeid;
            if (has_data && (in_nodeid != node))
               err_node <= 1'b1;
            if (state == S_STREAM_IN)
               err_len <= 1'b1;
         end else if (ingest_beat) begin
            if (ptr == PTR_W'(BEATS)) begin
               err_len <= 1'b1;
            end else begin
               acc[ptr_idx] <= add_beat(acc[ptr_idx], in_data);
               ptr          <= ptr_inc;
            end
         end

         if (take_eos) begin
            done_q <= in_done_aggr;
            wb_q   <= in_wb_en;
         end

         if (state == S_END) begin
            if (has_data && (len != ptr))
               err_len <= 1'b1;
            if (ptr > len)
               len <= ptr;
            has_data <= 1'b1;
            ptr      <= '0;
         end

         if (rs_load || ob_load)
            ptr <= ptr_inc;

         if (drain_done) begin
            for (int b = 0; b < BEATS; b++)
               acc[b] <= '0;
            ptr      <= '0;
            len      <= '0;
            has_data <= 1'b0;
         end
      end
   end

endmodule
